// File: rtl/store_buffer_pkg.sv
// ----------------------------------------------------------------------------
// store_buffer_pkg
//   Shared sizing constants and types for the store buffer slice.
//   - SB_ENTRY     : number of store buffer entries (power of two, >= 2)
//   - WORD_SIZE_P  : address and data width
//   - sb_entry_t   : per-entry state {valid, exec, committed, addr, data}
//   - exe_sb_t     : address/data fill bundle from the LSU execute stage
//   - sb_dbg_t     : pointer/counter snapshot exported for observation
// ----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_ENTRY    = 8;
    localparam int WORD_SIZE_P = 16;
    localparam int SB_IDX_W    = $clog2(SB_ENTRY);
    localparam int SB_CNT_W    = SB_IDX_W + 1;

    typedef logic [SB_IDX_W-1:0]    sb_idx_t;
    typedef logic [SB_CNT_W-1:0]    sb_cnt_t;
    typedef logic [WORD_SIZE_P-1:0] word_t;

    typedef struct packed {
        logic  valid;
        logic  exec;
        logic  committed;
        word_t addr;
        word_t data;
    } sb_entry_t;

    typedef struct packed {
        logic    valid;
        sb_idx_t entry_num;
        word_t   addr;
        word_t   data;
    } exe_sb_t;

    typedef struct packed {
        sb_idx_t drain_pt;
        sb_idx_t commit_pt;
        sb_idx_t alloc_pt;
        sb_cnt_t num_total;
        sb_cnt_t num_commit;
    } sb_dbg_t;

endpackage

// File: rtl/store_buffer_if.sv
// ----------------------------------------------------------------------------
// store_buffer_if
//   Bundles every store buffer signal except clock and reset.
//   - issue side   : issue_sb_valid_i, sb_issue_ready_o, sb_issue_entry_num_o
//   - execute side : exe_sb_valid_i, exe_sb_entry_num_i, exe_sb_addr_i/data_i
//   - rob side     : rob_sb_valid_i, rob_mispredict_i
//   - memory side  : sb_mem_valid_o, sb_mem_addr_o/data_o, mem_sb_ready_i
//   - status       : sb_empty_o, sb_dbg_o (pointer/counter snapshot)
//   - SB_FORWARD_EN: adds ld_sb_valid_i, ld_sb_addr_i, sb_ld_hit_o, sb_ld_data_o
//   Modport slave is the store buffer; modport master is whoever drives it.
// ----------------------------------------------------------------------------
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic    issue_sb_valid_i;
    logic    sb_issue_ready_o;
    sb_idx_t sb_issue_entry_num_o;

    logic    exe_sb_valid_i;
    sb_idx_t exe_sb_entry_num_i;
    word_t   exe_sb_addr_i;
    word_t   exe_sb_data_i;

    logic    rob_sb_valid_i;
    logic    rob_mispredict_i;

    logic    sb_mem_valid_o;
    word_t   sb_mem_addr_o;
    word_t   sb_mem_data_o;
    logic    mem_sb_ready_i;

    logic    sb_empty_o;
    sb_dbg_t sb_dbg_o;

`ifdef SB_FORWARD_EN
    logic    ld_sb_valid_i;
    word_t   ld_sb_addr_i;
    logic    sb_ld_hit_o;
    word_t   sb_ld_data_o;
`endif

    modport slave (
`ifdef SB_FORWARD_EN
        input  ld_sb_valid_i, ld_sb_addr_i,
        output sb_ld_hit_o, sb_ld_data_o,
`endif
        input  issue_sb_valid_i, exe_sb_valid_i, exe_sb_entry_num_i,
        input  exe_sb_addr_i, exe_sb_data_i, rob_sb_valid_i, rob_mispredict_i,
        input  mem_sb_ready_i,
        output sb_issue_ready_o, sb_issue_entry_num_o, sb_mem_valid_o,
        output sb_mem_addr_o, sb_mem_data_o, sb_empty_o, sb_dbg_o
    );

    modport master (
`ifdef SB_FORWARD_EN
        output ld_sb_valid_i, ld_sb_addr_i,
        input  sb_ld_hit_o, sb_ld_data_o,
`endif
        output issue_sb_valid_i, exe_sb_valid_i, exe_sb_entry_num_i,
        output exe_sb_addr_i, exe_sb_data_i, rob_sb_valid_i, rob_mispredict_i,
        output mem_sb_ready_i,
        input  sb_issue_ready_o, sb_issue_entry_num_o, sb_mem_valid_o,
        input  sb_mem_addr_o, sb_mem_data_o, sb_empty_o, sb_dbg_o
    );

endinterface

// File: rtl/store_buffer_fwd_search.sv
// ----------------------------------------------------------------------------
// sb_fwd_search
//   Store-to-load forwarding search. Walks the buffer from drain_pt (oldest)
//   toward the tail; the last match seen is the youngest valid executed store
//   to the load address, so its data wins.
//   Ports:
//   - i_entries  : full entry array
//   - i_drain_pt : oldest entry index
//   - i_ld_valid : load lookup request
//   - i_ld_addr  : load address
//   - o_hit      : a matching store exists
//   - o_data     : data of the youngest matching store
// ----------------------------------------------------------------------------
module sb_fwd_search
    import store_buffer_pkg::*;
(
    input  sb_entry_t i_entries [SB_ENTRY],
    input  sb_idx_t   i_drain_pt,
    input  logic      i_ld_valid,
    input  word_t     i_ld_addr,
    output logic      o_hit,
    output word_t     o_data
);

    sb_idx_t w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < SB_ENTRY; i++) begin
            w_idx = i_drain_pt + sb_idx_t'(i);
            if (i_ld_valid && i_entries[w_idx].valid && i_entries[w_idx].exec &&
                (i_entries[w_idx].addr == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//   Holds speculative and committed stores between issue and memory.
//   Issue allocates entries at alloc_pt, the LSU fills address/data, the rob
//   promotes the oldest uncommitted entry (commit_pt) and committed entries
//   drain from drain_pt to memory in program order. A mispredict discards
//   every uncommitted entry while any same-cycle drain still completes.
//   Ports:
//   - clk_i   : clock
//   - reset_i : synchronous active-high reset
//   - sb      : store_buffer_if.slave (issue, execute, rob, memory, status)
//   Optional: define SB_FORWARD_EN to add store-to-load forwarding.
//
//   Handshakes: a transfer happens in a cycle where both valid and ready are
//   high at the rising edge. Memory side: sb_mem_valid_o does not depend on
//   mem_sb_ready_i and, once raised, addr/data/valid hold until accepted.
//   Issue side: issue_sb_valid_i with sb_issue_ready_o allocates one entry.
// ----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    store_buffer_if.slave sb
);

    sb_entry_t r_entries [SB_ENTRY];
    sb_idx_t   r_drain_pt;
    sb_idx_t   r_commit_pt;
    sb_idx_t   r_alloc_pt;
    sb_cnt_t   r_num_total;
    sb_cnt_t   r_num_commit;

    exe_sb_t   w_exe;
    sb_entry_t w_head;
    logic      w_issue_ready;
    logic      w_alloc;
    logic      w_commit;
    logic      w_mem_valid;
    logic      w_drain;
    sb_cnt_t   w_num_total_nxt;
    sb_cnt_t   w_num_commit_nxt;

    assign w_exe = '{valid:     sb.exe_sb_valid_i,
                     entry_num: sb.exe_sb_entry_num_i,
                     addr:      sb.exe_sb_addr_i,
                     data:      sb.exe_sb_data_i};

    assign w_head        = r_entries[r_drain_pt];
    assign w_issue_ready = (r_num_total != sb_cnt_t'(SB_ENTRY)) & ~sb.rob_mispredict_i;
    assign w_alloc       = sb.issue_sb_valid_i & w_issue_ready;
    assign w_commit      = sb.rob_sb_valid_i & ~sb.rob_mispredict_i;
    assign w_mem_valid   = w_head.valid & w_head.committed;
    assign w_drain       = w_mem_valid & sb.mem_sb_ready_i;

    // A mispredict keeps only committed entries, minus the one draining now.
    always_comb begin
        w_num_commit_nxt = r_num_commit + sb_cnt_t'(w_commit) - sb_cnt_t'(w_drain);
        w_num_total_nxt  = r_num_total + sb_cnt_t'(w_alloc) - sb_cnt_t'(w_drain);
        if (sb.rob_mispredict_i) begin
            w_num_total_nxt = r_num_commit - sb_cnt_t'(w_drain);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                r_entries[i] <= '0;
            end
            r_drain_pt   <= '0;
            r_commit_pt  <= '0;
            r_alloc_pt   <= '0;
            r_num_total  <= '0;
            r_num_commit <= '0;
        end else begin
            for (int i = 0; i < SB_ENTRY; i++) begin
                if (sb.rob_mispredict_i && !r_entries[i].committed) begin
                    r_entries[i] <= '0;
                end else begin
                    // Fills aimed at free slots are dropped.
                    if (w_exe.valid && (w_exe.entry_num == sb_idx_t'(i)) && r_entries[i].valid) begin
                        r_entries[i].exec <= 1'b1;
                        r_entries[i].addr <= w_exe.addr;
                        r_entries[i].data <= w_exe.data;
                    end
                    if (w_commit && (r_commit_pt == sb_idx_t'(i))) begin
                        r_entries[i].committed <= 1'b1;
                    end
                    if (w_drain && (r_drain_pt == sb_idx_t'(i))) begin
                        r_entries[i] <= '0;
                    end
                    // Allocation never targets the draining slot: full blocks it.
                    if (w_alloc && (r_alloc_pt == sb_idx_t'(i))) begin
                        r_entries[i].valid     <= 1'b1;
                        r_entries[i].exec      <= 1'b0;
                        r_entries[i].committed <= 1'b0;
                    end
                end
            end
            r_drain_pt   <= r_drain_pt + sb_idx_t'(w_drain);
            r_commit_pt  <= r_commit_pt + sb_idx_t'(w_commit);
            r_alloc_pt   <= sb.rob_mispredict_i ? r_commit_pt : (r_alloc_pt + sb_idx_t'(w_alloc));
            r_num_total  <= w_num_total_nxt;
            r_num_commit <= w_num_commit_nxt;
        end
    end

    assign sb.sb_issue_ready_o     = w_issue_ready;
    assign sb.sb_issue_entry_num_o = r_alloc_pt;
    assign sb.sb_mem_valid_o       = w_mem_valid;
    assign sb.sb_mem_addr_o        = w_head.addr;
    assign sb.sb_mem_data_o        = w_head.data;
    assign sb.sb_empty_o           = (r_num_total == '0);
    assign sb.sb_dbg_o             = '{drain_pt:   r_drain_pt,
                                       commit_pt:  r_commit_pt,
                                       alloc_pt:   r_alloc_pt,
                                       num_total:  r_num_total,
                                       num_commit: r_num_commit};

`ifdef SB_FORWARD_EN
    sb_fwd_search u_fwd_search (
        .i_entries  (r_entries),
        .i_drain_pt (r_drain_pt),
        .i_ld_valid (sb.ld_sb_valid_i),
        .i_ld_addr  (sb.ld_sb_addr_i),
        .o_hit      (sb.sb_ld_hit_o),
        .o_data     (sb.sb_ld_data_o)
    );
`endif

    // The rob may only commit an executed store, and only if one is pending.
    a_commit_exec : assert property (@(posedge clk_i) disable iff (reset_i)
        w_commit |-> r_entries[r_commit_pt].exec);
    a_commit_pending : assert property (@(posedge clk_i) disable iff (reset_i)
        w_commit |-> (r_num_commit != r_num_total));

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    store_buffer_if sb_if ();

    store_buffer dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sb      (sb_if)
    );

    // ---------------- scoreboard ----------------
    logic [2*WORD_SIZE_P-1:0] exp_q [$];
    logic [2*WORD_SIZE_P-1:0] exp_w;
    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        sb_if.issue_sb_valid_i   = 1'b0;
        sb_if.exe_sb_valid_i     = 1'b0;
        sb_if.exe_sb_entry_num_i = '0;
        sb_if.exe_sb_addr_i      = '0;
        sb_if.exe_sb_data_i      = '0;
        sb_if.rob_sb_valid_i     = 1'b0;
        sb_if.rob_mispredict_i   = 1'b0;
        sb_if.mem_sb_ready_i     = 1'b0;
`ifdef SB_FORWARD_EN
        sb_if.ld_sb_valid_i      = 1'b0;
        sb_if.ld_sb_addr_i       = '0;
`endif
    endtask

    task automatic reset_dut();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            sb_if.issue_sb_valid_i = 1'b1;
            tick();
        end
        sb_if.issue_sb_valid_i = 1'b0;
    endtask

    task automatic fill(input int idx, input word_t addr, input word_t data);
        sb_if.exe_sb_valid_i     = 1'b1;
        sb_if.exe_sb_entry_num_i = sb_idx_t'(idx);
        sb_if.exe_sb_addr_i      = addr;
        sb_if.exe_sb_data_i      = data;
        tick();
        sb_if.exe_sb_valid_i     = 1'b0;
    endtask

    task automatic commit_one(input word_t addr, input word_t data);
        sb_if.rob_sb_valid_i = 1'b1;
        exp_q.push_back({addr, data});
        tick();
        sb_if.rob_sb_valid_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_dut();
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b want 0", sb_if.sb_mem_valid_o); end
        n_cmp++; if (sb_if.sb_issue_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", sb_if.sb_issue_ready_o); end
        n_cmp++; if (sb_if.sb_empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", sb_if.sb_empty_o); end
        n_cmp++; if (sb_if.sb_issue_entry_num_o !== '0) begin n_err++; $display("FAIL reset_entry_num: got %0d want 0", sb_if.sb_issue_entry_num_o); end
        n_cmp++; if (sb_if.sb_mem_addr_o !== '0 || sb_if.sb_mem_data_o !== '0) begin n_err++; $display("FAIL reset_addr_data: got %h/%h want 0/0", sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o); end
        n_cmp++; if (sb_if.sb_dbg_o !== '0) begin n_err++; $display("FAIL reset_dbg: got %h want 0", sb_if.sb_dbg_o); end
    endtask

    task automatic test_alloc_wrap();
        word_t a, d;
        reset_dut();
        for (int i = 0; i < SB_ENTRY; i++) begin
            sb_if.issue_sb_valid_i = 1'b1;
            #1;
            n_cmp++;
            if (sb_if.sb_issue_ready_o !== 1'b1 || sb_if.sb_issue_entry_num_o !== sb_idx_t'(i)) begin
                n_err++; $display("FAIL alloc_entry_num[%0d]: got ready=%b num=%0d want ready=1 num=%0d", i, sb_if.sb_issue_ready_o, sb_if.sb_issue_entry_num_o, i);
            end
            tick();
        end
        sb_if.issue_sb_valid_i = 1'b0;
        n_cmp++; if (sb_if.sb_issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", sb_if.sb_issue_ready_o); end
        n_cmp++; if (sb_if.sb_empty_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", sb_if.sb_empty_o); end
        alloc_n(1);  // must be refused while full
        n_cmp++; if (sb_if.sb_dbg_o.num_total !== sb_cnt_t'(SB_ENTRY)) begin n_err++; $display("FAIL full_alloc_blocked: got num_total=%0d want %0d", sb_if.sb_dbg_o.num_total, SB_ENTRY); end
        a = word_t'($urandom_range(0, 16'hFFFF));
        d = word_t'($urandom_range(0, 16'hFFFF));
        fill(0, a, d);
        commit_one(a, d);
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1) begin n_err++; $display("FAIL wrap_mem_valid: got %b want 1", sb_if.sb_mem_valid_o); end
        sb_if.mem_sb_ready_i = 1'b1;
        exp_w = exp_q.pop_front();
        n_cmp++; if ({sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin n_err++; $display("FAIL wrap_drain: got %h want %h", {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w); end
        tick();
        sb_if.mem_sb_ready_i = 1'b0;
        n_cmp++; if (sb_if.sb_issue_ready_o !== 1'b1 || sb_if.sb_issue_entry_num_o !== '0) begin n_err++; $display("FAIL wrap_ready: got ready=%b num=%0d want ready=1 num=0", sb_if.sb_issue_ready_o, sb_if.sb_issue_entry_num_o); end
        alloc_n(1);
        n_cmp++; if (sb_if.sb_dbg_o.alloc_pt !== sb_idx_t'(1) || sb_if.sb_dbg_o.num_total !== sb_cnt_t'(SB_ENTRY)) begin n_err++; $display("FAIL wrap_alloc: got alloc_pt=%0d num_total=%0d want 1/%0d", sb_if.sb_dbg_o.alloc_pt, sb_if.sb_dbg_o.num_total, SB_ENTRY); end
    endtask

    task automatic test_drain_hold();
        reset_dut();
        alloc_n(2);
        fill(0, 16'h0010, 16'hBEEF);
        commit_one(16'h0010, 16'hBEEF);
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1 || sb_if.sb_mem_addr_o !== 16'h0010 || sb_if.sb_mem_data_o !== 16'hBEEF) begin
            n_err++; $display("FAIL hold_first: got v=%b a=%h d=%h want v=1 a=0010 d=beef", sb_if.sb_mem_valid_o, sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1 || sb_if.sb_mem_addr_o !== 16'h0010 || sb_if.sb_mem_data_o !== 16'hBEEF) begin
                n_err++; $display("FAIL hold_stable[%0d]: got v=%b a=%h d=%h want v=1 a=0010 d=beef", c, sb_if.sb_mem_valid_o, sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o);
            end
        end
        sb_if.mem_sb_ready_i = 1'b1;
        exp_w = exp_q.pop_front();
        n_cmp++; if ({sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin n_err++; $display("FAIL hold_drain: got %h want %h", {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w); end
        tick();
        sb_if.mem_sb_ready_i = 1'b0;
        n_cmp++; if (sb_if.sb_dbg_o.num_total !== sb_cnt_t'(1) || sb_if.sb_mem_valid_o !== 1'b0 || sb_if.sb_empty_o !== 1'b0) begin
            n_err++; $display("FAIL hold_after: got num_total=%0d v=%b empty=%b want 1/0/0", sb_if.sb_dbg_o.num_total, sb_if.sb_mem_valid_o, sb_if.sb_empty_o);
        end
    endtask

    task automatic test_mispredict();
        word_t a [4];
        word_t d [4];
        int cyc;
        reset_dut();
        alloc_n(4);
        for (int i = 0; i < 4; i++) begin
            a[i] = word_t'($urandom_range(0, 16'hFFFF));
            d[i] = word_t'($urandom_range(0, 16'hFFFF));
            fill(i, a[i], d[i]);
        end
        commit_one(a[0], d[0]);
        commit_one(a[1], d[1]);
        sb_if.rob_mispredict_i = 1'b1;
        sb_if.issue_sb_valid_i = 1'b1;
        #1;
        n_cmp++; if (sb_if.sb_issue_ready_o !== 1'b0) begin n_err++; $display("FAIL misp_ready: got %b want 0", sb_if.sb_issue_ready_o); end
        tick();
        sb_if.rob_mispredict_i = 1'b0;
        sb_if.issue_sb_valid_i = 1'b0;
        n_cmp++; if (sb_if.sb_dbg_o.num_total !== sb_cnt_t'(2) || sb_if.sb_dbg_o.alloc_pt !== sb_idx_t'(2) || sb_if.sb_dbg_o.num_commit !== sb_cnt_t'(2)) begin
            n_err++; $display("FAIL misp_state: got total=%0d alloc=%0d commit=%0d want 2/2/2", sb_if.sb_dbg_o.num_total, sb_if.sb_dbg_o.alloc_pt, sb_if.sb_dbg_o.num_commit);
        end
        sb_if.mem_sb_ready_i = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin
            if (sb_if.sb_mem_valid_o === 1'b1) begin
                exp_w = exp_q.pop_front();
                n_cmp++; if ({sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin n_err++; $display("FAIL misp_drain: got %h want %h", {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w); end
            end
            tick();
            cyc++;
        end
        sb_if.mem_sb_ready_i = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL misp_drain_timeout: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (sb_if.sb_empty_o !== 1'b1 || sb_if.sb_mem_valid_o !== 1'b0) begin n_err++; $display("FAIL misp_empty: got empty=%b v=%b want 1/0", sb_if.sb_empty_o, sb_if.sb_mem_valid_o); end
    endtask

    task automatic test_mispredict_drain();
        reset_dut();
        alloc_n(4);
        for (int i = 0; i < 4; i++) fill(i, word_t'(16'h0100 + i), word_t'(16'hC000 + i));
        commit_one(16'h0100, 16'hC000);
        sb_if.rob_mispredict_i = 1'b1;
        sb_if.mem_sb_ready_i   = 1'b1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1 || {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin
            n_err++; $display("FAIL mispdrain_head: got v=%b %h want v=1 %h", sb_if.sb_mem_valid_o, {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w);
        end
        tick();
        idle();
        n_cmp++; if (sb_if.sb_empty_o !== 1'b1 || sb_if.sb_mem_valid_o !== 1'b0 || sb_if.sb_dbg_o.num_total !== '0 || sb_if.sb_dbg_o.num_commit !== '0) begin
            n_err++; $display("FAIL mispdrain_empty: got empty=%b v=%b total=%0d commit=%0d want 1/0/0/0", sb_if.sb_empty_o, sb_if.sb_mem_valid_o, sb_if.sb_dbg_o.num_total, sb_if.sb_dbg_o.num_commit);
        end
        n_cmp++; if (sb_if.sb_dbg_o.alloc_pt !== sb_idx_t'(1) || sb_if.sb_dbg_o.drain_pt !== sb_idx_t'(1)) begin
            n_err++; $display("FAIL mispdrain_ptrs: got alloc=%0d drain=%0d want 1/1", sb_if.sb_dbg_o.alloc_pt, sb_if.sb_dbg_o.drain_pt);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        alloc_n(3);
        for (int i = 0; i < 3; i++) fill(i, word_t'(16'h0200 + i), word_t'(16'hD000 + i));
        commit_one(16'h0200, 16'hD000);
        // commit + drain + allocate in the same cycle
        sb_if.rob_sb_valid_i   = 1'b1;
        sb_if.issue_sb_valid_i = 1'b1;
        sb_if.mem_sb_ready_i   = 1'b1;
        exp_w = exp_q.pop_front();
        exp_q.push_back({16'h0201, 16'hD001});
        n_cmp++; if ({sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin n_err++; $display("FAIL b2b_drain0: got %h want %h", {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w); end
        tick();
        sb_if.rob_sb_valid_i   = 1'b0;
        sb_if.issue_sb_valid_i = 1'b0;
        n_cmp++; if (sb_if.sb_dbg_o.num_total !== sb_cnt_t'(3) || sb_if.sb_dbg_o.num_commit !== sb_cnt_t'(1)) begin
            n_err++; $display("FAIL b2b_counts: got total=%0d commit=%0d want 3/1", sb_if.sb_dbg_o.num_total, sb_if.sb_dbg_o.num_commit);
        end
        n_cmp++; if (sb_if.sb_dbg_o.alloc_pt !== sb_idx_t'(4) || sb_if.sb_dbg_o.drain_pt !== sb_idx_t'(1) || sb_if.sb_dbg_o.commit_pt !== sb_idx_t'(2)) begin
            n_err++; $display("FAIL b2b_ptrs: got alloc=%0d drain=%0d commit=%0d want 4/1/2", sb_if.sb_dbg_o.alloc_pt, sb_if.sb_dbg_o.drain_pt, sb_if.sb_dbg_o.commit_pt);
        end
        exp_w = exp_q.pop_front();
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1 || {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o} !== exp_w) begin
            n_err++; $display("FAIL b2b_drain1: got v=%b %h want v=1 %h", sb_if.sb_mem_valid_o, {sb_if.sb_mem_addr_o, sb_if.sb_mem_data_o}, exp_w);
        end
        tick();
        sb_if.mem_sb_ready_i = 1'b0;
        n_cmp++; if (sb_if.sb_dbg_o.num_total !== sb_cnt_t'(2) || sb_if.sb_dbg_o.num_commit !== '0 || sb_if.sb_mem_valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_after: got total=%0d commit=%0d v=%b want 2/0/0", sb_if.sb_dbg_o.num_total, sb_if.sb_dbg_o.num_commit, sb_if.sb_mem_valid_o);
        end
    endtask

    task automatic test_reset_mid_drain();
        reset_dut();
        alloc_n(1);
        fill(0, 16'h0300, 16'hE000);
        commit_one(16'h0300, 16'hE000);
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_valid_before: got %b want 1", sb_if.sb_mem_valid_o); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_q.delete();
        n_cmp++; if (sb_if.sb_mem_valid_o !== 1'b0 || sb_if.sb_empty_o !== 1'b1 || sb_if.sb_issue_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_outputs: got v=%b empty=%b ready=%b want 0/1/1", sb_if.sb_mem_valid_o, sb_if.sb_empty_o, sb_if.sb_issue_ready_o);
        end
        n_cmp++; if (sb_if.sb_dbg_o !== '0) begin n_err++; $display("FAIL rstmid_ptrs: got %h want 0", sb_if.sb_dbg_o); end
    endtask

`ifdef SB_FORWARD_EN
    task automatic test_forward();
        reset_dut();
        alloc_n(2);
        fill(0, 16'h0020, 16'h1111);
        fill(1, 16'h0020, 16'h2222);
        sb_if.ld_sb_valid_i = 1'b1;
        sb_if.ld_sb_addr_i  = 16'h0020;
        #1;
        n_cmp++; if (sb_if.sb_ld_hit_o !== 1'b1 || sb_if.sb_ld_data_o !== 16'h2222) begin
            n_err++; $display("FAIL fwd_hit: got hit=%b data=%h want 1/2222", sb_if.sb_ld_hit_o, sb_if.sb_ld_data_o);
        end
        sb_if.ld_sb_addr_i = 16'h0030;
        #1;
        n_cmp++; if (sb_if.sb_ld_hit_o !== 1'b0) begin n_err++; $display("FAIL fwd_miss: got hit=%b want 0", sb_if.sb_ld_hit_o); end
        sb_if.ld_sb_valid_i = 1'b0;
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        reset_i = 1'b1;
        idle();
        test_reset();
        test_alloc_wrap();
        test_drain_hold();
        test_mispredict();
        test_mispredict_drain();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef SB_FORWARD_EN
        test_forward();
`endif
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Holds speculative and committed stores between issue and memory.
- Receiving end of the rob-store buffer interface: the commit pulse (`rob_sb_valid`) promotes the oldest pending store to committed; mispredict discards all uncommitted stores.
- Committed stores drain in program order to the data-memory write port over a valid/ready handshake.
- Sits beside the rob; fed by issue (allocation) and the LSU execute stage (address/data fill).

Parameters:
- SB_ENTRY, 8, number of entries; power of two, >= 2.
- WORD_SIZE_P, 16, address and data width (package constant).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- issue_sb_valid_i  in  1  issue requests allocation of one store entry
- sb_issue_ready_o  out  1  free entry available and no mispredict this cycle
- sb_issue_entry_num_o  out  $clog2(SB_ENTRY)  index being allocated (equals alloc_pt)
- exe_sb_valid_i  in  1  LSU writes address/data of an executed store
- exe_sb_entry_num_i  in  $clog2(SB_ENTRY)  target entry
- exe_sb_addr_i  in  WORD_SIZE_P  store address
- exe_sb_data_i  in  WORD_SIZE_P  store data
- rob_sb_valid_i  in  1  rob commits the oldest uncommitted store
- rob_mispredict_i  in  1  flush uncommitted entries
- sb_mem_valid_o  out  1  head entry committed and executed, write pending
- sb_mem_addr_o  out  WORD_SIZE_P  head address
- sb_mem_data_o  out  WORD_SIZE_P  head data
- mem_sb_ready_i  in  1  memory accepts the write
- sb_empty_o  out  1  no entries (committed or speculative) held

Behaviour:
- State:
  - entries {valid, exec, committed, addr, data};
  - pointers drain_pt (head), commit_pt (oldest uncommitted), alloc_pt (tail), all $clog2(SB_ENTRY) wide, wrap naturally;
  - counters num_total, num_commit, $clog2(SB_ENTRY)+1 wide.
- Reset: all entries cleared, pointers 0, counters 0. Outputs: sb_mem_valid_o=0, sb_issue_ready_o=1, sb_empty_o=1, sb_issue_entry_num_o=0, addr/data 0.
- Allocate:
  - Fires when issue_sb_valid_i & sb_issue_ready_o.
  - Sets entry[alloc_pt].valid=1 and clears exec/committed; alloc_pt++, num_total++.
  - sb_issue_ready_o = (num_total != SB_ENTRY) & ~rob_mispredict_i.
- Execute fill: exe_sb_valid_i sets exec, addr, data of the indexed entry next cycle. Fill to an invalid entry is ignored.
- Commit:
  - On rob_sb_valid_i & ~rob_mispredict_i: entry[commit_pt].committed=1, commit_pt++, num_commit++.
  - The entry must already be exec=1; otherwise a simulation assertion fires.
  - Commit when num_commit == num_total is an assertion error.
- Drain:
  - sb_mem_valid_o = entry[drain_pt].valid & committed (combinational from registered state).
  - On valid & mem_sb_ready_i: entry cleared, drain_pt++, num_total--, num_commit--.
- Mispredict:
  - alloc_pt <= commit_pt.
  - All non-committed entries are cleared.
  - num_total <= num_commit, adjusted by the drain decrement if a drain happens the same cycle.
  - Allocation and commit are blocked that cycle.
  - Drain proceeds normally, so committed stores are never lost.
- Simultaneous events: allocate+drain in the same cycle means num_total unchanged. Commit+drain means num_commit unchanged. Full (num_total==SB_ENTRY) blocks allocation only.
- sb_empty_o = (num_total == 0).
- Outputs hold stable while sb_mem_valid_o=1 and mem_sb_ready_i=0.

Optional Feature:
- SB_FORWARD_EN adds ports ld_sb_valid_i, ld_sb_addr_i (WORD_SIZE_P), sb_ld_hit_o, sb_ld_data_o.
- Combinational search from the youngest valid exec entry toward drain_pt. The hit returns that entry's data.
- Without the macro: ports absent, no search logic.

Decomposition:
- Package: SB_ENTRY, the sb_entry_t struct {valid, exec, committed, addr, data}, and the exe_sb_t fill-bundle struct.
- Natural sub-module: sb_fwd_search (age-ordered priority match), instantiated only under SB_FORWARD_EN.

Test Plan:
- Fill SB_ENTRY=8 allocations -> entry nums 0..7, sb_issue_ready_o=0 after 8th; drain one committed -> ready=1, next alloc gets 0 (wrap).
- Alloc 2, fill entry0 addr=0x0010 data=0xBEEF, commit -> next cycle sb_mem_valid_o=1 addr 0x0010 data 0xBEEF; hold mem_sb_ready_i=0 3 cycles -> outputs stable; ready=1 -> entry drained, num_total=1.
- Alloc 4, commit 2, mispredict -> num_total=2, alloc_pt=2, both committed stores drain in order, sb_empty_o=1 after.
- Mispredict same cycle as drain handshake with 1 committed + 3 speculative -> next cycle sb_empty_o=1.
- Reset asserted mid-drain with sb_mem_valid_o=1 -> next cycle valid=0, empty=1, pointers 0.
- (SB_FORWARD_EN) two stores to 0x0020 data 0x1111 then 0x2222, load 0x0020 -> hit=1, data 0x2222; load 0x0030 -> hit=0.
